// File: rtl/alu_op_sequencer.sv
// Control sequencer for the 8-bit ALU/accumulator datapath: decodes an 8085 ALU-class
// opcode and walks IDLE -> [OPND] -> LOAD -> EXEC -> WB, driving datapath and flag strobes.
module alu_op_sequencer #(
  parameter int unsigned OPND_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] opcode,
  input  logic       operand_valid,
  input  logic       cy_in,
  input  logic       a_lsb,
  input  logic       a_msb,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       abort,
  output logic       operand_req,
  output logic       write_dbus_to_alu_tmp,
  output logic       a_to_act,
  output logic       dbus_to_act,
  output logic       sel_0_fe,
  output logic       fe_0_to_act,
  output logic       alu_to_a,
  output logic       sel_alu_a,
  output logic       alu_a_to_dbus,
  output logic [4:0] alu_sel,
  output logic       shift_right_in,
  output logic       alu_cin_n,
  output logic       flag_we,
  output logic [4:0] flag_mask,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_OPND = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

  logic [2:0]  state;
  logic [7:0]  op_q;
  logic [15:0] wait_cnt;
  logic        illegal_q, abort_q;
  logic [4:0]  sel_q;
  logic        cin_n_q, sri_q;

  logic [4:0]  dec_sel, dec_mask;
  logic        dec_cin_n, dec_sri, use_fe, fe_val, wb_acc, wb_reg;
  logic [2:0]  ooo;

  function automatic logic is_legal(input logic [7:0] op);
    is_legal = (op[7:6] == 2'b10) ||
               (op[7:6] == 2'b11 && op[2:0] == 3'b110) ||
               (op[7:6] == 2'b00 && op[2:1] == 2'b10) ||
               op == 8'h07 || op == 8'h17 || op == 8'h0F ||
               op == 8'h1F || op == 8'h2F;
  endfunction

  // Right rotates take A straight into ACT; every other legal opcode fetches a dbus operand.
  function automatic logic needs_operand(input logic [7:0] op);
    needs_operand = is_legal(op) && !(op == 8'h0F || op == 8'h1F);
  endfunction

  assign ooo = op_q[5:3];

  always_comb begin
    dec_sel   = 5'b00000;
    dec_cin_n = 1'b1;
    dec_sri   = 1'b0;
    dec_mask  = 5'b00000;
    use_fe    = 1'b0;
    fe_val    = 1'b0;
    wb_acc    = 1'b0;
    wb_reg    = 1'b0;
    if (op_q[7]) begin
      dec_mask = 5'b11111;
      wb_acc   = (ooo != 3'b111);
      case (ooo)
        3'b000:  dec_sel = 5'b10000;
        3'b001:  begin dec_sel = 5'b10000; dec_cin_n = ~cy_in; end
        3'b010:  begin dec_sel = 5'b10100; dec_cin_n = 1'b0; end
        3'b011:  begin dec_sel = 5'b10100; dec_cin_n = cy_in; end
        3'b100:  dec_sel = 5'b11010;
        3'b101:  dec_sel = 5'b10010;
        3'b110:  dec_sel = 5'b00010;
        default: begin dec_sel = 5'b10100; dec_cin_n = 1'b0; end
      endcase
    end else if (op_q[7:6] == 2'b00 && op_q[2:1] == 2'b10) begin
      // INR adds 00h+operand+1, DCR adds FEh+operand+1.
      dec_sel   = 5'b10000;
      dec_cin_n = 1'b0;
      dec_mask  = 5'b11110;
      use_fe    = 1'b1;
      fe_val    = op_q[0];
      wb_acc    = (ooo == 3'b111);
      wb_reg    = (ooo != 3'b111);
    end else begin
      case (op_q)
        8'h07:   begin dec_sel = 5'b10000; dec_cin_n = ~a_msb; dec_mask = 5'b00001; wb_acc = 1'b1; end
        8'h17:   begin dec_sel = 5'b10000; dec_cin_n = ~cy_in; dec_mask = 5'b00001; wb_acc = 1'b1; end
        8'h0F:   begin dec_sel = 5'b00011; dec_sri = a_lsb; dec_mask = 5'b00001; wb_acc = 1'b1; end
        8'h1F:   begin dec_sel = 5'b00011; dec_sri = cy_in; dec_mask = 5'b00001; wb_acc = 1'b1; end
        8'h2F:   begin dec_sel = 5'b10010; wb_acc = 1'b1; end
        default: dec_sel = 5'b00000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= 8'h00;
      wait_cnt  <= 16'd0;
      illegal_q <= 1'b0;
      abort_q   <= 1'b0;
      sel_q     <= 5'b00000;
      cin_n_q   <= 1'b1;
      sri_q     <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      abort_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_legal(opcode)) begin
              op_q     <= opcode;
              wait_cnt <= 16'd0;
              state    <= needs_operand(opcode) ? S_OPND : S_LOAD;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        S_OPND: begin
          if (operand_valid) begin
            state <= S_LOAD;
          end else if (OPND_TIMEOUT != 0 && (wait_cnt + 16'd1) == OPND_TIMEOUT[15:0]) begin
            abort_q <= 1'b1;
            state   <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_LOAD: state <= S_EXEC;
        S_EXEC: begin
          // Freeze the function select so it stays stable through writeback.
          sel_q   <= dec_sel;
          cin_n_q <= dec_cin_n;
          sri_q   <= dec_sri;
          state   <= S_WB;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy                  = (state != S_IDLE);
    done                  = (state == S_WB);
    illegal               = illegal_q;
    abort                 = abort_q;
    operand_req           = (state == S_OPND);
    write_dbus_to_alu_tmp = (state == S_OPND) && operand_valid;
    a_to_act              = (state == S_LOAD) && !use_fe;
    dbus_to_act           = 1'b0;
    sel_0_fe              = (state == S_LOAD) && use_fe;
    fe_0_to_act           = (state == S_LOAD) && use_fe && fe_val;
    alu_to_a              = (state == S_WB) && wb_acc;
    sel_alu_a             = (state == S_WB) && wb_reg;
    alu_a_to_dbus         = (state == S_WB) && wb_reg;
    flag_we               = (state == S_WB) && (dec_mask != 5'b00000);
    flag_mask             = (state == S_WB) ? dec_mask : 5'b00000;
    alu_sel               = 5'b00000;
    alu_cin_n             = 1'b1;
    shift_right_in        = 1'b0;
    if (state == S_EXEC) begin
      alu_sel        = dec_sel;
      alu_cin_n      = dec_cin_n;
      shift_right_in = dec_sri;
    end else if (state == S_WB) begin
      alu_sel        = sel_q;
      alu_cin_n      = cin_n_q;
      shift_right_in = sri_q;
    end
    state_dbg = state;
  end

endmodule
